// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
package mem_arb_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   is_store;
   } inflight_t;

   // Seeding the pointer with IF makes LS win the first contested cycle.
   localparam owner_e RR_RESET_LAST = OWN_IF;

   function automatic owner_e rr_next(input owner_e last);
      owner_e nxt;
      if (last == OWN_IF) nxt = OWN_LS;
      else                nxt = OWN_IF;
      return nxt;
   endfunction

endpackage

// File: rtl/rsp_hold.sv
// rtl/rsp_hold.sv - per-port response slot: pass-through with a 1-entry holding register
module rsp_hold #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  rsp_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  blocked
);

   logic                  hold_valid_q, hold_valid_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

   // A fresh result and a held one never coexist: the arbiter withholds
   // grants while this slot is blocked.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      if (hold_valid_q) begin
         if (rsp_ready) hold_valid_d = 1'b0;
      end else if (in_valid && !rsp_ready) begin
         hold_valid_d = 1'b1;
         hold_data_d  = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
      end
   end

   always_comb begin
      rsp_valid = hold_valid_q | in_valid;
      rsp_data  = '0;
      if (hold_valid_q)  rsp_data = hold_data_q;
      else if (in_valid) rsp_data = in_data;
      // Full now, or about to capture a result the consumer is refusing.
      blocked   = hold_valid_q | (in_valid & ~rsp_ready);
   end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - round-robin arbiter sharing one single-cycle RAM between fetch and load/store
module mem_arb #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-1:0] if_req_addr,
   output logic                  if_req_ready,
   output logic                  if_rsp_valid,
   output logic [DATA_WIDTH-1:0] if_rsp_data,
   input  logic                  if_rsp_ready,
   input  logic                  ls_req_valid,
   input  logic                  ls_req_wen,
   input  logic [ADDR_WIDTH-1:0] ls_req_addr,
   input  logic [DATA_WIDTH-1:0] ls_req_wdata,
   output logic                  ls_req_ready,
   output logic                  ls_rsp_valid,
   output logic [DATA_WIDTH-1:0] ls_rsp_data,
   input  logic                  ls_rsp_ready,
   output logic                  ram_en,
   output logic                  ram_wen,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   input  logic                  ram_ready
);

   import mem_arb_pkg::*;

   inflight_t             inflight_q, inflight_d;
   owner_e                last_q, last_d;
   owner_e                grant;
   logic                  if_blocked, ls_blocked;
   logic                  if_elig, ls_elig, issue;
   logic                  if_in_valid, ls_in_valid;
   logic [DATA_WIDTH-1:0] ls_in_data;

   always_comb begin
      if_elig = if_req_valid && !if_blocked;
      ls_elig = ls_req_valid && !ls_blocked;
      issue   = rst && ram_ready && (if_elig || ls_elig);
      grant   = OWN_LS;
      if (if_elig && ls_elig) grant = rr_next(last_q);
      else if (if_elig)       grant = OWN_IF;
   end

   always_comb begin
      last_d              = last_q;
      inflight_d          = '0;
      inflight_d.valid    = issue;
      inflight_d.owner    = grant;
      inflight_d.is_store = issue && (grant == OWN_LS) && ls_req_wen;
      if (issue) last_d = grant;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight_q <= '0;
         last_q     <= RR_RESET_LAST;
      end else begin
         inflight_q <= inflight_d;
         last_q     <= last_d;
      end
   end

   always_comb begin
      ram_en       = issue;
      ram_wen      = 1'b0;
      ram_addr     = '0;
      ram_wdata    = '0;
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
      if (issue) begin
         if (grant == OWN_IF) begin
            if_req_ready = 1'b1;
            ram_addr     = if_req_addr;
         end else begin
            ls_req_ready = 1'b1;
            ram_addr     = ls_req_addr;
            ram_wen      = ls_req_wen;
            if (ls_req_wen) ram_wdata = ls_req_wdata;
         end
      end
   end

   // RAM data belongs to last cycle's issue; stores acknowledge with zero.
   always_comb begin
      if_in_valid = inflight_q.valid && (inflight_q.owner == OWN_IF);
      ls_in_valid = inflight_q.valid && (inflight_q.owner == OWN_LS);
      ls_in_data  = inflight_q.is_store ? '0 : ram_rdata;
   end

   rsp_hold #(.DATA_WIDTH(DATA_WIDTH)) u_if_hold (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (if_in_valid),
      .in_data   (ram_rdata),
      .rsp_ready (if_rsp_ready),
      .rsp_valid (if_rsp_valid),
      .rsp_data  (if_rsp_data),
      .blocked   (if_blocked)
   );

   rsp_hold #(.DATA_WIDTH(DATA_WIDTH)) u_ls_hold (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (ls_in_valid),
      .in_data   (ls_in_data),
      .rsp_ready (ls_rsp_ready),
      .rsp_valid (ls_rsp_valid),
      .rsp_data  (ls_rsp_data),
      .blocked   (ls_blocked)
   );

endmodule
